// File: rtl/axi_rd_ram_bridge.sv
// AXI4 read-only slave that turns AR bursts into single-word RAM reads.
// Returned words pass through a 2-entry skid FIFO so R back-pressure never loses a beat.
module axi_rd_ram_bridge #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [AXI_ID_WIDTH-1:0]                     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]                   s_axi_araddr,
    input  logic [7:0]                                  s_axi_arlen,
    input  logic [1:0]                                  s_axi_arburst,
    input  logic                                        s_axi_arvalid,
    output logic                                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]                     s_axi_rid,
    output logic [AXI_WIDTH-1:0]                        s_axi_rdata,
    output logic [1:0]                                  s_axi_rresp,
    output logic                                        s_axi_rlast,
    output logic                                        s_axi_rvalid,
    input  logic                                        s_axi_rready,
    output logic                                        ram_ren,
    output logic [AXI_ADDR_WIDTH-$clog2(AXI_WIDTH)+2:0] ram_addr,
    input  logic [AXI_WIDTH-1:0]                        ram_data
);
    localparam int LSB = $clog2(AXI_WIDTH) - 3;
    localparam int RAW = AXI_ADDR_WIDTH - LSB;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [7:0]              len_q;
    logic [1:0]              resp_q;
    logic [8:0]              iss_cnt;
    logic [8:0]              ret_cnt;
    logic                    pend;
    logic [AXI_WIDTH-1:0]    mem0, mem1;
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic                    pop;
    logic [2:0]              occ;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // once valid is raised the payload stays stable until that edge.
    assign pop = s_axi_rvalid && s_axi_rready;
    assign occ = {1'b0, count} + {2'b00, pend};

    // Only issue when the word can land in the FIFO, counting the beat leaving this cycle.
    assign ram_ren = (state == BURST) && (iss_cnt <= {1'b0, len_q}) &&
                     (occ < (3'd2 + {2'b00, pop}));

    assign s_axi_rvalid = (count != 2'd0);
    assign s_axi_rdata  = rd_ptr ? mem1 : mem0;
    assign s_axi_rlast  = s_axi_rvalid && (ret_cnt == {1'b0, len_q});
    assign s_axi_rid    = id_q;
    assign s_axi_rresp  = resp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            s_axi_arready <= 1'b0;
            id_q          <= '0;
            len_q         <= '0;
            resp_q        <= '0;
            iss_cnt       <= '0;
            ret_cnt       <= '0;
            pend          <= 1'b0;
            mem0          <= '0;
            mem1          <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
            ram_addr      <= '0;
        end else begin
            pend  <= ram_ren;
            count <= count + {1'b0, pend} - {1'b0, pop};
            if (ram_ren) begin
                ram_addr <= ram_addr + 1'b1;
                iss_cnt  <= iss_cnt + 9'd1;
            end
            if (pend) begin
                if (wr_ptr) mem1 <= ram_data;
                else        mem0 <= ram_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                ret_cnt <= ret_cnt + 9'd1;
            end
            case (state)
                IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        id_q          <= s_axi_arid;
                        len_q         <= s_axi_arlen;
                        resp_q        <= (s_axi_arburst == 2'b01) ? 2'b00 : 2'b10;
                        ram_addr      <= RAW'(s_axi_araddr >> LSB);
                        iss_cnt       <= '0;
                        ret_cnt       <= '0;
                        s_axi_arready <= 1'b0;
                        state         <= BURST;
                    end
                end
                BURST: begin
                    if (pop && s_axi_rlast) begin
                        s_axi_arready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_ram_bridge.sv
// Bench for axi_rd_ram_bridge: reference beat list per AR, a monitor popping it on R handshakes,
// plus directed latency, streaming, reset and address-wrap cases.
module tb_axi_rd_ram_bridge;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [5:0]   arid = '0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic [1:0]   arburst = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [5:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b1;
  logic         ram_ren;
  logic [27:0]  ram_addr;
  logic [127:0] ram_data = '0;

  axi_rd_ram_bridge #(.AXI_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int outstanding = 0;
  int beats = 0;
  bit rready_rand = 1'b0;

  logic [127:0] exp_q[$];
  logic [8:0]   exp_meta_q[$];
  logic [27:0]  exp_addr_q[$];

  function automatic logic [127:0] word_of(input logic [27:0] a);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = {4'h0, a};
    return w;
  endfunction

  // memory: word w holds w replicated, one cycle after the strobe
  always @(posedge clk) if (ram_ren) ram_data <= word_of(ram_addr);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // stimulus driver for rready, changed just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    rready = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  bit           st_v = 1'b0;
  logic [127:0] st_data;
  logic [8:0]   st_meta;
  bit           mpop;

  always @(negedge clk) begin
    if (!rstn) begin
      st_v = 1'b0;
    end else begin
      mpop = rvalid && rready;
      if (st_v) begin
        check("stall_valid", 128'(rvalid), 128'd1);
        check("stall_data", rdata, st_data);
        check("stall_meta", 128'({rid, rresp, rlast}), 128'(st_meta));
      end
      st_v    = rvalid && !rready;
      st_data = rdata;
      st_meta = {rid, rresp, rlast};
      if (ram_ren) begin
        if (exp_addr_q.size() == 0) fail("ren_extra");
        else check("ram_addr", 128'(ram_addr), 128'(exp_addr_q.pop_front()));
      end
      check("occupancy_le2", 128'((outstanding + int'(ram_ren) - int'(mpop)) <= 2), 128'd1);
      outstanding = outstanding + int'(ram_ren) - int'(mpop);
      if (mpop) begin
        if (exp_q.size() == 0) fail("beat_extra");
        else begin
          check("rdata", rdata, exp_q.pop_front());
          check("rid_rresp_rlast", 128'({rid, rresp, rlast}), 128'(exp_meta_q.pop_front()));
        end
        beats++;
      end
    end
  end

  task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    logic [27:0] b;
    int n;
    bit hs;
    b = addr[31:4];
    for (int i = 0; i <= int'(len); i++) begin
      exp_addr_q.push_back(b + 28'(i));
      exp_q.push_back(word_of(b + 28'(i)));
      exp_meta_q.push_back({id, (burst == 2'b01) ? 2'b00 : 2'b10, i == int'(len)});
    end
    @(posedge clk);
    #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid = 1'b0;
    if (!hs) fail("ar_timeout");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drained", 128'(exp_q.size() + exp_addr_q.size()), 128'd0);
  endtask

  initial begin
    int n;
    int b0;
    repeat (3) @(negedge clk);
    check("rst_arready", 128'(arready), 128'd0);
    check("rst_rvalid", 128'(rvalid), 128'd0);
    check("rst_rlast", 128'(rlast), 128'd0);
    check("rst_ram_ren", 128'(ram_ren), 128'd0);
    check("rst_zero_outs", {rdata[127:40], rid, rresp, ram_addr}, 128'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("arready_after_rst", 128'(arready), 128'd1);

    // single beat, latency 0 -> 1 -> 3
    do_ar(6'h01, 32'h100, 8'd0, 2'b01);
    @(negedge clk);
    check("lat_ren_c1", 128'(ram_ren), 128'd1);
    check("lat_addr_c1", 128'(ram_addr), 128'h10);
    check("lat_rvalid_c1", 128'(rvalid), 128'd0);
    @(negedge clk);
    check("lat_ren_c2", 128'(ram_ren), 128'd0);
    check("lat_rvalid_c2", 128'(rvalid), 128'd0);
    @(negedge clk);
    check("lat_rvalid_c3", 128'(rvalid), 128'd1);
    check("lat_rdata_c3", rdata, word_of(28'h10));
    check("lat_rlast_c3", 128'(rlast), 128'd1);
    check("lat_rresp_c3", 128'(rresp), 128'd0);
    @(negedge clk);
    check("arready_after_last", 128'(arready), 128'd1);
    wait_drain();

    // 8-beat stream with no bubbles
    do_ar(6'h02, 32'h100, 8'd7, 2'b01);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("stream_ren", 128'(ram_ren), 128'(c <= 8));
      if (c >= 3) check("stream_rvalid", 128'(rvalid), 128'd1);
      check("stream_rlast", 128'(rlast), 128'(c == 10));
    end
    wait_drain();

    // 16 beats under random back-pressure
    rready_rand = 1'b1;
    do_ar(6'h05, $urandom() & 32'hFFFF_FFF0, 8'd15, 2'b01);
    wait_drain();
    rready_rand = 1'b0;

    // non-INCR burst reports SLVERR
    do_ar(6'h2A, 32'h40, 8'd3, 2'b10);
    wait_drain();

    // word-address wrap
    do_ar(6'h03, 32'hFFFF_FFF0, 8'd1, 2'b01);
    wait_drain();

    // random bursts
    rready_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_ar(6'($urandom()), $urandom(), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
      wait_drain();
    end
    rready_rand = 1'b0;

    // reset in the middle of a burst
    b0 = beats;
    do_ar(6'h07, 32'h0, 8'd7, 2'b01);
    n = 0;
    while (beats < b0 + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached_beat3", 128'(beats >= b0 + 3), 128'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rvalid", 128'(rvalid), 128'd0);
    check("mid_rst_ram_ren", 128'(ram_ren), 128'd0);
    check("mid_rst_arready", 128'(arready), 128'd0);
    check("mid_rst_rlast", 128'(rlast), 128'd0);
    exp_q.delete();
    exp_meta_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_arready", 128'(arready), 128'd1);
    do_ar(6'h08, 32'h200, 8'd1, 2'b01);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
